autobaud_detect: RTL and testbench

Measures the bit period of an incoming 0x55 sync character on the UART receive line and classifies it into the 3-bit baud-select code used by the baud-rate generator: 000=9600, 001=19200, 010=38400, 011=57600, 100=115200. It runs on the 100 MHz system clock, sits between the `rx` pin and the baud-generator `select` input, and is armed by the host before the remote end sends its sync byte.

---
 rtl/autobaud_detect.sv | 191 +++++++++++++++++++
 tb/tb_autobaud_detect.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/autobaud_detect.sv
// autobaud_detect: times the bit period of an incoming 0x55 sync character
// on the UART receive line and turns it into the baud-generator select code
// (000=9600, 001=19200, 010=38400, 011=57600, 100=115200).
//
// Handshake: arm is a single-cycle request honoured only in IDLE; busy rises
// the cycle after arm is sampled and falls together with the one-cycle done
// (success) or err (failure) pulse. select/locked change only with done.
module autobaud_detect #(
    parameter int MIN_PULSE = 651,
    parameter int MAX_PULSE = 15625,
    parameter int IDLE_MIN  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       arm,
    output logic [2:0] select,
    output logic       locked,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [2:0] dbg_state
);

    localparam int HW = $clog2(IDLE_MIN + 1);

    localparam logic [HW-1:0] IDLE_MIN_C = HW'(IDLE_MIN);
    localparam logic [13:0]   MIN_P      = 14'(MIN_PULSE);
    localparam logic [13:0]   MAX_P      = 14'(MAX_PULSE);

    // Period thresholds (clk cycles per bit) separating the baud classes.
    localparam logic [13:0] TH_9600  = 14'd7812;
    localparam logic [13:0] TH_19200 = 14'd3906;
    localparam logic [13:0] TH_38400 = 14'd2170;
    localparam logic [13:0] TH_57600 = 14'd1302;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_HIGH  = 3'd1,
        S_WAIT_START = 3'd2,
        S_MEASURE    = 3'd3,
        S_CLASSIFY   = 3'd4
    } state_t;

    state_t      r_state;
    logic        r_rx_meta;
    logic        r_rx_sync;
    logic        r_rx_prev;
    logic [HW-1:0] r_hcnt;
    logic [16:0] r_t;
    logic [13:0] r_p;
    logic [3:0]  r_e;
    logic [2:0]  r_select;
    logic        r_locked;
    logic        r_busy;
    logic        r_done;
    logic        r_err;

    logic          w_edge;
    logic          w_fall;
    logic [HW-1:0] w_h_inc;
    logic [16:0]   w_t_inc;
    logic [13:0]   w_p_inc;
    logic [3:0]    w_e_inc;
    logic [13:0]   w_q;
    logic [2:0]    w_sel;

    assign w_edge  = r_rx_sync ^ r_rx_prev;
    assign w_fall  = r_rx_prev & ~r_rx_sync;
    assign w_h_inc = r_hcnt + 1'b1;
    assign w_t_inc = r_t + 17'd1;
    assign w_p_inc = r_p + 14'd1;
    assign w_e_inc = r_e + 4'd1;
    // Latched T spans 8 bit periods, so the per-bit period is T/8.
    assign w_q     = r_t[16:3];

    assign select    = r_select;
    assign locked    = r_locked;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign dbg_state = r_state;

    // Two-flop synchronizer plus one delayed copy for edge detection; idle high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // Map the measured period onto the baud-select code.
    always_comb begin
        w_sel = 3'b100;
        if (w_q >= TH_9600)       w_sel = 3'b000;
        else if (w_q >= TH_19200) w_sel = 3'b001;
        else if (w_q >= TH_38400) w_sel = 3'b010;
        else if (w_q >= TH_57600) w_sel = 3'b011;
    end

    // Detection state machine with registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_hcnt   <= '0;
            r_t      <= '0;
            r_p      <= '0;
            r_e      <= '0;
            r_select <= 3'b000;
            r_locked <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (arm) begin
                        r_state <= S_WAIT_HIGH;
                        r_hcnt  <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_WAIT_HIGH: begin
                    // Require a clean idle-high stretch so we start on a real start bit.
                    if (r_rx_sync) begin
                        if (w_h_inc == IDLE_MIN_C) begin
                            r_state <= S_WAIT_START;
                        end else begin
                            r_hcnt <= w_h_inc;
                        end
                    end else begin
                        r_hcnt <= '0;
                    end
                end
                S_WAIT_START: begin
                    if (w_fall) begin
                        r_state <= S_MEASURE;
                        r_t     <= '0;
                        r_p     <= '0;
                        r_e     <= '0;
                    end
                end
                S_MEASURE: begin
                    r_t <= w_t_inc;
                    r_p <= w_p_inc;
                    if (w_edge) begin
                        if (w_p_inc < MIN_P) begin
                            r_err   <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_p <= '0;
                            r_e <= w_e_inc;
                            // 8th edge after the start edge closes the 8-bit window.
                            if (w_e_inc == 4'd8) begin
                                r_state <= S_CLASSIFY;
                            end
                        end
                    end else if (w_p_inc >= MAX_P) begin
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_CLASSIFY: begin
                    if ((w_q < MIN_P) || (w_q > MAX_P)) begin
                        r_err <= 1'b1;
                    end else begin
                        r_select <= w_sel;
                        r_locked <= 1'b1;
                        r_done   <= 1'b1;
                    end
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_autobaud_detect.sv
// Bench for autobaud_detect: drives 0x55 sync frames at several bit periods
// and checks every done/err result against an expected-record queue.
module tb_autobaud_detect;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       arm;
  logic [2:0] select;
  logic       locked;
  logic       busy;
  logic       done;
  logic       err;
  logic [2:0] dbg_state;

  // Result record: {done, err, locked, select}
  localparam int W = 6;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v;
  logic [W-1:0] act_v;

  int checks = 0;
  int errors = 0;

  // Bench-side model of the sticky outputs.
  logic       m_locked;
  logic [2:0] m_select;

  typedef struct {
    int         period;
    logic [2:0] code;
  } vec_t;

  vec_t vecs[6];

  autobaud_detect dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .arm       (arm),
    .select    (select),
    .locked    (locked),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Start bit, 0x55 LSB first, then a short stop/idle high.
  task automatic send_frame(input int period, input bit jitter);
    logic [8:0] lv;
    int per;
    lv = 9'b010101010;
    for (int i = 0; i < 9; i++) begin
      rx = lv[i];
      per = period;
      if (jitter) per = period + int'($urandom_range(40)) - 20;
      tick(per);
    end
    rx = 1'b1;
    tick(50);
  endtask

  task automatic push_ok(input logic [2:0] code);
    exp_q.push_back({1'b1, 1'b0, 1'b1, code});
    m_locked = 1'b1;
    m_select = code;
  endtask

  task automatic push_err();
    exp_q.push_back({1'b0, 1'b1, m_locked, m_select});
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && (done || err)) begin
      act_v = {done, err, locked, select};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got %b, none expected", act_v);
      end else begin
        exp_v = exp_q.pop_front();
        if (act_v !== exp_v) begin
          errors++;
          $display("FAIL result: got %b expected %b", act_v, exp_v);
        end
      end
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL busy_with_result: got %b expected 0", busy);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    vecs[0] = '{868,   3'b100};
    vecs[1] = '{10417, 3'b000};
    vecs[2] = '{5208,  3'b001};
    vecs[3] = '{1736,  3'b011};
    vecs[4] = '{1302,  3'b011};
    vecs[5] = '{1301,  3'b100};

    m_locked = 1'b0;
    m_select = 3'b000;
    rst = 1'b1;
    rx  = 1'b1;
    arm = 1'b0;
    tick(4);
    check("reset_outputs", {26'd0, select, locked, busy, done, err}, 32'd0);
    check("reset_state", {29'd0, dbg_state}, 32'd0);
    rst = 1'b0;
    tick(100);

    // Table-driven frames
    for (int i = 0; i < 6; i++) begin
      tick(30);
      do_arm();
      check("busy_after_arm", {31'd0, busy}, 32'd1);
      tick(20);
      check("wait_start_reached", {29'd0, dbg_state}, 32'd2);
      push_ok(vecs[i].code);
      send_frame(vecs[i].period, 1'b0);
      check("result_seen", exp_q.size(), 32'd0);
      check("idle_after_frame", {29'd0, dbg_state, busy}, 32'd0);
    end

    // 57600 with per-bit jitter
    tick(30);
    do_arm();
    tick(20);
    push_ok(3'b011);
    send_frame(1736, 1'b1);
    check("jitter_result_seen", exp_q.size(), 32'd0);
    // Restore a 115200 lock for the timeout case.
    tick(30);
    do_arm();
    tick(20);
    push_ok(3'b100);
    send_frame(868, 1'b0);
    check("relock_result_seen", exp_q.size(), 32'd0);

    // Line held low: timeout at pulse cycle 15625 (+3 for sync and edge register)
    tick(30);
    do_arm();
    tick(20);
    push_err();
    rx = 1'b0;
    n = 0;
    for (int k = 1; k <= 17000; k++) begin
      tick(1);
      if (err) begin
        n = k;
        break;
      end
    end
    check("timeout_latency", n, 32'd15628);
    tick(20000 - n);
    rx = 1'b1;
    tick(50);
    check("timeout_result_seen", exp_q.size(), 32'd0);
    check("timeout_keeps_lock", {28'd0, locked, select}, {28'd0, 1'b1, 3'b100});

    // Arm while rx low, then a short low glitch
    rx = 1'b0;
    tick(5);
    do_arm();
    tick(50);
    check("no_progress_low", {29'd0, dbg_state}, 32'd1);
    rx = 1'b1;
    tick(15);
    check("still_wait_high", {29'd0, dbg_state}, 32'd1);
    tick(5);
    check("wait_start_after_high", {29'd0, dbg_state}, 32'd2);
    push_err();
    rx = 1'b0;
    tick(100);
    rx = 1'b1;
    tick(50);
    check("glitch_result_seen", exp_q.size(), 32'd0);
    check("glitch_idle", {29'd0, dbg_state, busy}, 32'd0);

    // Reset during MEASURE
    tick(30);
    do_arm();
    tick(20);
    rx = 1'b0;
    tick(2604);
    rx = 1'b1;
    tick(1000);
    check("in_measure", {29'd0, dbg_state}, 32'd3);
    #3;
    rst = 1'b1;
    #1;
    check("mid_reset_outputs", {26'd0, select, locked, busy, done, err}, 32'd0);
    m_locked = 1'b0;
    m_select = 3'b000;
    tick(3);
    rst = 1'b0;
    tick(30);
    check("no_restart_without_arm", {29'd0, dbg_state}, 32'd0);
    do_arm();
    tick(20);
    push_ok(3'b010);
    send_frame(2604, 1'b0);
    check("post_reset_result_seen", exp_q.size(), 32'd0);
    check("post_reset_lock", {28'd0, locked, select}, {28'd0, 1'b1, 3'b010});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
